// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM state
// encoding and default sizing constants.
package program_loader_pkg;

   localparam int DEF_ADDR_W          = 6;
   localparam int DEF_DEPTH           = 64;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_HI,
      WAIT_LO,
      WRITE,
      FULL
   } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Instruction-memory write port driven by the program loader.
interface program_loader_if
   import program_loader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [15:0]       wr_data;

   modport master (output wr_en, wr_addr, wr_data);
   modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/program_loader_button_debouncer.sv
// Push-button conditioning: 2-FF synchronizer, hold-time debounce counter and
// a one-cycle press pulse on each accepted rising edge.
module button_debouncer
   import program_loader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clk_enable,
   input  logic button,
   output logic press
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             stable_dly_q;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The stable level flips on the last counted cycle of an unbroken run at the new level.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      press_d  = stable_q & ~stable_dly_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
         press_q      <= 1'b0;
      end else if (clk_enable) begin
         sync1_q      <= button;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         cnt_q        <= cnt_d;
         press_q      <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/program_loader.sv
// Loads 16-bit instructions into instruction memory from two button-captured
// switch bytes. Optional macro PROGRAM_LOADER_ECHO_EN adds the echo_data display port.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int DEPTH           = DEF_DEPTH,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clk_enable,
   input  logic                   button,
   input  logic [7:0]             input_instruction,
   input  logic                   load_mode,
   program_loader_if.master       wr_port,
   output logic                   byte_phase,
   output logic [ADDR_W:0]        load_count,
`ifdef PROGRAM_LOADER_ECHO_EN
   output logic                   full,
   output logic [15:0]            echo_data
`else
   output logic                   full
`endif
);

   logic press;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .button     (button),
      .press      (press)
   );

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic [7:0]        hi_byte_q, hi_byte_d;
   logic              byte_phase_q, byte_phase_d;
   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic              full_q, full_d;
`ifdef PROGRAM_LOADER_ECHO_EN
   logic [15:0]       echo_q, echo_d;
`endif

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      hi_byte_d    = hi_byte_q;
      byte_phase_d = byte_phase_q;
      load_count_d = load_count_q;
      full_d       = full_q;
`ifdef PROGRAM_LOADER_ECHO_EN
      echo_d       = echo_q;
`endif

      case (state_q)
         IDLE: begin
            if (load_mode) state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (!load_mode) begin
               state_d = IDLE;
            end else if (press) begin
               hi_byte_d    = input_instruction;
               byte_phase_d = 1'b1;
               state_d      = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (!load_mode) begin
               state_d = IDLE;
            end else if (press) begin
               wr_data_d = {hi_byte_q, input_instruction};
               state_d   = WRITE;
            end
         end
         WRITE: begin
            byte_phase_d = 1'b0;
            load_count_d = load_count_q + 1'b1;
`ifdef PROGRAM_LOADER_ECHO_EN
            echo_d       = wr_data_q;
`endif
            if (!load_mode) begin
               state_d = IDLE;
            end else if (int'(load_count_q) == DEPTH - 1) begin
               // Address stays on the last slot so it never appears to wrap.
               full_d  = 1'b1;
               state_d = FULL;
            end else begin
               wr_addr_d = wr_addr_q + 1'b1;
               state_d   = WAIT_HI;
            end
         end
         FULL: begin
            if (!load_mode) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Entering or sitting in IDLE discards all load progress.
      if (state_d == IDLE) begin
         wr_addr_d    = '0;
         load_count_d = '0;
         full_d       = 1'b0;
         byte_phase_d = 1'b0;
`ifdef PROGRAM_LOADER_ECHO_EN
         echo_d       = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         hi_byte_q    <= '0;
         byte_phase_q <= 1'b0;
         load_count_q <= '0;
         full_q       <= 1'b0;
`ifdef PROGRAM_LOADER_ECHO_EN
         echo_q       <= '0;
`endif
      end else if (clk_enable) begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         hi_byte_q    <= hi_byte_d;
         byte_phase_q <= byte_phase_d;
         load_count_q <= load_count_d;
         full_q       <= full_d;
`ifdef PROGRAM_LOADER_ECHO_EN
         echo_q       <= echo_d;
`endif
      end
   end

   assign wr_port.wr_en   = (state_q == WRITE);
   assign wr_port.wr_addr = wr_addr_q;
   assign wr_port.wr_data = wr_data_q;
   assign byte_phase      = byte_phase_q;
   assign load_count      = load_count_q;
   assign full            = full_q;
`ifdef PROGRAM_LOADER_ECHO_EN
   assign echo_data       = (state_q == WAIT_LO) ? {hi_byte_q, 8'h00} : echo_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the
// stimulus and matched by an independent write-strobe monitor.
module tb_program_loader;

   typedef struct packed {
      logic [5:0]  addr;
      logic [15:0] data;
   } wr_exp_t;

   logic        clk;
   logic        reset;
   logic        clk_enable;
   logic        button;
   logic [7:0]  input_instruction;
   logic        load_mode;
   logic        byte_phase;
   logic [6:0]  load_count;
   logic        full;
`ifdef PROGRAM_LOADER_ECHO_EN
   logic [15:0] echo_data;
`endif

   int      tests_run;
   int      tests_failed;
   wr_exp_t exp_q[$];
   logic    prev_wr_en;

   program_loader_if #(.ADDR_W(6)) wr_bus ();

   program_loader dut (
      .clk               (clk),
      .reset             (reset),
      .clk_enable        (clk_enable),
      .button            (button),
      .input_instruction (input_instruction),
      .load_mode         (load_mode),
      .wr_port           (wr_bus.master),
      .byte_phase        (byte_phase),
      .load_count        (load_count),
`ifdef PROGRAM_LOADER_ECHO_EN
      .full              (full),
      .echo_data         (echo_data)
`else
      .full              (full)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One clean press with the switches set to sw, followed by a full release.
   task automatic applyStimulus(input logic [7:0] sw);
      input_instruction = sw;
      button = 1'b1;
      repeat (24) tick();
      button = 1'b0;
      repeat (24) tick();
   endtask

   task automatic expectWrite(input logic [5:0] addr, input logic [15:0] data);
      wr_exp_t e;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: every new write strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset && wr_bus.wr_en && !prev_wr_en) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_write: got addr %0d data 0x%04h, expected no write",
                     wr_bus.wr_addr, wr_bus.wr_data);
         end else begin
            wr_exp_t e;
            e = exp_q.pop_front();
            if (wr_bus.wr_addr !== e.addr || wr_bus.wr_data !== e.data) begin
               tests_failed++;
               $display("[TB] FAIL write: got addr %0d data 0x%04h, expected addr %0d data 0x%04h",
                        wr_bus.wr_addr, wr_bus.wr_data, e.addr, e.data);
            end
         end
      end
      prev_wr_en = reset & wr_bus.wr_en;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      prev_wr_en        = 1'b0;
      tests_run         = 0;
      tests_failed      = 0;
      reset             = 1'b0;
      clk_enable        = 1'b1;
      button            = 1'b0;
      input_instruction = 8'h00;
      load_mode         = 1'b0;
      repeat (3) tick();

      checkOutput("rst_wr_en",      32'(wr_bus.wr_en),   32'd0);
      checkOutput("rst_wr_addr",    32'(wr_bus.wr_addr), 32'd0);
      checkOutput("rst_wr_data",    32'(wr_bus.wr_data), 32'd0);
      checkOutput("rst_byte_phase", 32'(byte_phase),     32'd0);
      checkOutput("rst_load_count", 32'(load_count),     32'd0);
      checkOutput("rst_full",       32'(full),           32'd0);

      reset = 1'b1;
      repeat (2) tick();
      load_mode = 1'b1;
      repeat (2) tick();

      // Basic pair A5 / 3C.
      applyStimulus(8'hA5);
      checkOutput("first_hi_phase", 32'(byte_phase), 32'd1);
      expectWrite(6'd0, 16'hA53C);
      applyStimulus(8'h3C);
      checkOutput("first_count", 32'(load_count), 32'd1);
      checkOutput("first_phase", 32'(byte_phase), 32'd0);
      checkOutput("first_data",  32'(wr_bus.wr_data), 32'hA53C);

      // Bouncy press: 8 segments of 5 cycles, then a solid 20-cycle hold.
      input_instruction = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         button = (i % 2 == 0);
         repeat (5) tick();
      end
      button = 1'b1;
      repeat (20) tick();
      button = 1'b0;
      repeat (24) tick();
      checkOutput("bounce_phase", 32'(byte_phase), 32'd1);
      checkOutput("bounce_count", 32'(load_count), 32'd1);
      expectWrite(6'd1, 16'h5A77);
      applyStimulus(8'h77);
      checkOutput("bounce_pair_count", 32'(load_count), 32'd2);

      // Abandoned high byte followed by a fresh load.
      applyStimulus(8'hFF);
      checkOutput("abort_hi_phase", 32'(byte_phase), 32'd1);
      load_mode = 1'b0;
      repeat (2) tick();
      checkOutput("abort_phase", 32'(byte_phase), 32'd0);
      checkOutput("abort_count", 32'(load_count), 32'd0);
      load_mode = 1'b1;
      repeat (2) tick();
      expectWrite(6'd0, 16'h1234);
      applyStimulus(8'h12);
      applyStimulus(8'h34);
      checkOutput("reload_count", 32'(load_count), 32'd1);

      // Fill all 64 slots with data equal to the address.
      load_mode = 1'b0;
      repeat (2) tick();
      load_mode = 1'b1;
      repeat (2) tick();
      for (int i = 0; i < 64; i++) begin
         expectWrite(6'(i), 16'(i));
         applyStimulus(8'h00);
         applyStimulus(8'(i));
         if (i == 62) begin
            checkOutput("fill63_full",  32'(full),       32'd0);
            checkOutput("fill63_count", 32'(load_count), 32'd63);
         end
      end
      checkOutput("fill_full",  32'(full),       32'd1);
      checkOutput("fill_count", 32'(load_count), 32'd64);
      applyStimulus(8'hAA);
      applyStimulus(8'hBB);
      checkOutput("over_count", 32'(load_count), 32'd64);
      checkOutput("over_full",  32'(full),       32'd1);
      checkOutput("over_phase", 32'(byte_phase), 32'd0);

      load_mode = 1'b0;
      repeat (2) tick();
      checkOutput("idle_full",  32'(full),       32'd0);
      checkOutput("idle_count", 32'(load_count), 32'd0);
      load_mode = 1'b1;
      repeat (2) tick();

      // A press made entirely while the clock enable is low is invisible.
      clk_enable = 1'b0;
      input_instruction = 8'h9E;
      button = 1'b1;
      repeat (40) tick();
      button = 1'b0;
      repeat (60) tick();
      clk_enable = 1'b1;
      repeat (30) tick();
      checkOutput("gated_phase", 32'(byte_phase), 32'd0);

      // Same press enabled: event after 19 cycles, byte_phase one cycle later.
      button = 1'b1;
      repeat (19) tick();
      checkOutput("latency_early", 32'(byte_phase), 32'd0);
      tick();
      checkOutput("latency_taken", 32'(byte_phase), 32'd1);
      repeat (4) tick();
      button = 1'b0;
      repeat (24) tick();
      expectWrite(6'd0, 16'h9EC3);
      applyStimulus(8'hC3);
      checkOutput("enabled_count", 32'(load_count), 32'd1);

      // Two more writes, then a high byte, and reset while waiting for the low byte.
      expectWrite(6'd1, 16'h0102);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      expectWrite(6'd2, 16'h0304);
      applyStimulus(8'h03);
      applyStimulus(8'h04);
      applyStimulus(8'h44);
      checkOutput("pre_rst_phase", 32'(byte_phase),     32'd1);
      checkOutput("pre_rst_count", 32'(load_count),     32'd3);
      checkOutput("pre_rst_addr",  32'(wr_bus.wr_addr), 32'd3);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_wr_en",  32'(wr_bus.wr_en),   32'd0);
      checkOutput("mid_rst_addr",   32'(wr_bus.wr_addr), 32'd0);
      checkOutput("mid_rst_data",   32'(wr_bus.wr_data), 32'd0);
      checkOutput("mid_rst_phase",  32'(byte_phase),     32'd0);
      checkOutput("mid_rst_count",  32'(load_count),     32'd0);
      checkOutput("mid_rst_full",   32'(full),           32'd0);
      repeat (2) tick();
      reset = 1'b1;
      repeat (4) tick();

      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Front-end stage that fills the 64-entry instruction memory from the board's 8-bit switch bank and push-button before the processor runs. Each debounced button press captures one byte from the switches. Two presses (high byte, then low byte) form one 16-bit instruction, which is written to the next sequential program address. The block drives the instruction memory's write port and reports load progress; the datapath only fetches once `load_mode` is released.

## Interface
- `ADDR_W`, 6, instruction-memory address width
- `DEPTH`, 64, number of instruction slots (must equal 2**ADDR_W)
- `DEBOUNCE_CYCLES`, 16, consecutive enabled cycles a synchronized button level must hold to be accepted
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clk_enable`  in  1  global advance enable; when low, all state (including debounce counter) holds
- `button`  in  1  raw, asynchronous push-button
- `input_instruction`  in  8  switch byte
- `load_mode`  in  1  1 = loading permitted; 0 = run mode, loader idle
- `wr_en`  out  1  one-cycle instruction-memory write strobe
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  16  assembled instruction {high, low}
- `byte_phase`  out  1  0 = expecting high byte, 1 = expecting low byte
- `load_count`  out  ADDR_W+1  instructions written since load start (0..DEPTH)
- `full`  out  1  all DEPTH slots written

## Operation
- Button path: 2-FF synchronizer, then debounce counter. The stable level changes only after DEBOUNCE_CYCLES consecutive enabled cycles at the new level; any mismatch clears the counter. A press event is a rising edge of the stable level, one cycle wide.
- FSM states:
  - IDLE: entered at reset or whenever `load_mode`=0. Clears the address, count, `full` and `byte_phase`. Moves to WAIT_HI when `load_mode`=1.
  - WAIT_HI: on press, latch `input_instruction` as the high byte, set `byte_phase`=1, go to WAIT_LO.
  - WAIT_LO: on press, latch the low byte into `wr_data`, go to WRITE.
  - WRITE: assert `wr_en` for one cycle at the current `wr_addr`. Next cycle: increment `wr_addr` and `load_count`, clear `byte_phase`. If `load_count` reaches DEPTH, set `full` and go to FULL; otherwise go to WAIT_HI.
  - FULL: ignore presses, `wr_en`=0. Leaves only through IDLE.
- `load_mode` falling in any state goes to IDLE the next cycle. A pending high byte is discarded; a WRITE already in progress completes its strobe first.
- Presses arriving in IDLE, WRITE or FULL are dropped, not queued.
- `wr_addr` wraps are impossible: FULL blocks further writes after address DEPTH-1.
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `byte_phase`=0, `load_count`=0, `full`=0, FSM=IDLE, stable button=0, debounce counter=0.

## Timing
- Press latency: raw edge to press event = 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle (19 enabled cycles at defaults).
- Low-byte press event to `wr_en` high: 1 cycle. `wr_addr`/`wr_data` are stable for the whole strobe cycle.
- `load_count`/`full` update the cycle after the strobe.
- Cycles with `clk_enable`=0 are invisible: no counting, no transitions, outputs hold (a strobe extends if `clk_enable` drops during WRITE).
- Reset asserted mid-operation clears everything immediately and asynchronously; release is taken synchronously.

## Configuration
- `PROGRAM_LOADER_ECHO_EN` defined: adds output `echo_data` [15:0]. Shows {high byte, 8'h00} in WAIT_LO, and the last written instruction otherwise (0 after reset/IDLE). It feeds the seven-segment display during loading.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package `program_loader_pkg`: FSM state enum (IDLE, WAIT_HI, WAIT_LO, WRITE, FULL), default constants for ADDR_W, DEPTH, DEBOUNCE_CYCLES.
- One sub-module: `button_debouncer` (synchronizer, counter, rising-edge press pulse, with `clk_enable` and active-low async `reset`).

## Test plan
- Reset, then `load_mode`=1, clean presses with switches 8'hA5 then 8'h3C -> single `wr_en` at `wr_addr`=0 with `wr_data`=16'hA53C, then `load_count`=1, `byte_phase`=0.
- Bouncy press (level toggles every 5 cycles for 40 cycles, then holds high 20 cycles) -> exactly one press event, `byte_phase` 0->1, no `wr_en`.
- 64 instructions loaded (data = address) -> last write at `wr_addr`=63, `full`=1, `load_count`=64. A 65th press pair produces no `wr_en`.
- High byte 8'hFF entered, then `load_mode`=0, then `load_mode`=1, then bytes 8'h12, 8'h34 -> write 16'h1234 at address 0.
- `clk_enable` held low for 100 cycles across a press -> no press event; the same press with `clk_enable`=1 is accepted after 19 enabled cycles.
- Reset pulsed while in WAIT_LO with `load_count`=3 -> all outputs return to reset values immediately, FSM=IDLE.
